// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Hazard and forwarding controller for a 5-stage RV32I pipeline. It keeps a
//   shadow copy of the EX, MEM and WB slot information. This shadow state
//   advances in lockstep with the datapath pipeline registers. From it the
//   block drives the operand and store-data mux selects and the pipeline
//   freeze, stall and flush controls.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   id_*                      decode-stage instruction info (valid, sources,
//                             source usage, store flag, destination,
//                             regwrite, regfilemux code)
//   br_taken                  EX stage redirects the PC
//   imem_wait, dmem_wait      I-cache / D-cache have not responded yet
//   rs1mux_sel, rs2mux_sel    EX operand selects (0 rs_out, 1 exmem_alu_out,
//                             2 exmem_br_en, 3 regfilemux_out, 4 mem_rdata,
//                             5 exmem_u_imm)
//   dcachemux_sel             MEM store data (0 rs2_out, 1 regfilemux_out)
//   freeze                    every pipeline register holds
//   stall_front               PC, IF/ID, ID/EX hold; EX/MEM takes a bubble
//   flush                     IF/ID and ID/EX take bubbles
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int unsigned REG_IDX_W     = 5,
  parameter bit          MEM_RDATA_FWD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_is_store,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_regwrite,
  input  logic [2:0]           id_wb_sel,
  input  logic                 br_taken,
  input  logic                 imem_wait,
  input  logic                 dmem_wait,
  output logic [2:0]           rs1mux_sel,
  output logic [2:0]           rs2mux_sel,
  output logic                 dcachemux_sel,
  output logic                 freeze,
  output logic                 stall_front,
  output logic                 flush
);

  // regfilemux codes of the producing instruction
  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_BR   = 3'd1;
  localparam logic [2:0] WB_UIMM = 3'd2;
  localparam logic [2:0] WB_MDR  = 3'd3;

  // operand mux codes
  localparam logic [2:0] SEL_RS_OUT    = 3'd0;
  localparam logic [2:0] SEL_EXMEM_ALU = 3'd1;
  localparam logic [2:0] SEL_EXMEM_BR  = 3'd2;
  localparam logic [2:0] SEL_REGFILE   = 3'd3;
  localparam logic [2:0] SEL_MEM_RDATA = 3'd4;
  localparam logic [2:0] SEL_EXMEM_U   = 3'd5;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 uses1;
    logic                 uses2;
    logic                 is_store;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic [2:0]           wb_sel;
  } ex_slot_t;

  // Nothing consumes the rs1/uses flags of the MEM occupant, so only the
  // fields that feed a decision are kept.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs2;
    logic                 is_store;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic [2:0]           wb_sel;
  } mem_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
  } wb_slot_t;

  ex_slot_t  ex_q,  ex_d;
  mem_slot_t mem_q, mem_d;
  wb_slot_t  wb_q,  wb_d;

  logic [3:0] rs1_res_s;
  logic [3:0] rs2_res_s;
  logic       hazard_s;
  logic       freeze_s;
  logic       flush_s;

  // A slot produces register r; x0 is never a forwarding target.
  function automatic logic reg_match(input logic                 valid,
                                     input logic                 regwrite,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] r);
    return valid & regwrite & (rd == r) & (r != {REG_IDX_W{1'b0}});
  endfunction

  // Result is {hazard, select}. MEM has priority over WB because it holds
  // the younger write to the same register.
  function automatic logic [3:0] src_fwd(input logic       consumer_v,
                                         input logic       uses,
                                         input logic       mem_hit,
                                         input logic [2:0] mem_wb_sel,
                                         input logic       wb_hit);
    logic [3:0] res;
    res = {1'b0, SEL_RS_OUT};
    if (consumer_v && uses && mem_hit) begin
      case (mem_wb_sel)
        WB_ALU:  res = {1'b0, SEL_EXMEM_ALU};
        WB_BR:   res = {1'b0, SEL_EXMEM_BR};
        WB_UIMM: res = {1'b0, SEL_EXMEM_U};
        WB_MDR: begin
          if (MEM_RDATA_FWD) res = {1'b0, SEL_MEM_RDATA};
          else               res = {1'b1, SEL_RS_OUT};
        end
        // pc_plus4 has no EX/MEM copy; unused codes are treated the same way
        default: res = {1'b1, SEL_RS_OUT};
      endcase
    end else if (consumer_v && uses && wb_hit) begin
      res = {1'b0, SEL_REGFILE};
    end else begin
      res = {1'b0, SEL_RS_OUT};
    end
    return res;
  endfunction

  assign rs1_res_s = src_fwd(ex_q.valid, ex_q.uses1,
                             reg_match(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs1),
                             mem_q.wb_sel,
                             reg_match(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs1));
  assign rs2_res_s = src_fwd(ex_q.valid, ex_q.uses2,
                             reg_match(mem_q.valid, mem_q.regwrite, mem_q.rd, ex_q.rs2),
                             mem_q.wb_sel,
                             reg_match(wb_q.valid, wb_q.regwrite, wb_q.rd, ex_q.rs2));

  assign hazard_s = rs1_res_s[3] | rs2_res_s[3];
  assign freeze_s = imem_wait | dmem_wait;
  // Branch operands are not trustworthy while stalled, so a stall masks it.
  assign flush_s  = br_taken & ex_q.valid & ~hazard_s & ~freeze_s;

  assign rs1mux_sel    = rs1_res_s[2:0];
  assign rs2mux_sel    = rs2_res_s[2:0];
  assign dcachemux_sel = mem_q.valid & mem_q.is_store &
                         reg_match(wb_q.valid, wb_q.regwrite, wb_q.rd, mem_q.rs2);
  assign freeze        = freeze_s;
  assign stall_front   = hazard_s & ~freeze_s;
  assign flush         = flush_s;

  // Slot advance: freeze holds everything, a hazard holds EX and bubbles MEM.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze_s) begin
      wb_d.valid    = mem_q.valid;
      wb_d.rd       = mem_q.rd;
      wb_d.regwrite = mem_q.regwrite;
      if (hazard_s) begin
        mem_d = '0;
        ex_d  = ex_q;
      end else begin
        mem_d.valid    = ex_q.valid;
        mem_d.rs2      = ex_q.rs2;
        mem_d.is_store = ex_q.is_store;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.wb_sel   = ex_q.wb_sel;
        if (flush_s) begin
          ex_d = '0;
        end else begin
          ex_d.valid    = id_valid;
          ex_d.rs1      = id_rs1;
          ex_d.rs2      = id_rs2;
          ex_d.uses1    = id_uses_rs1;
          ex_d.uses2    = id_uses_rs2;
          ex_d.is_store = id_is_store;
          ex_d.rd       = id_rd;
          ex_d.regwrite = id_regwrite;
          ex_d.wb_sel   = id_wb_sel;
        end
      end
    end else begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Drives two instances (mem_rdata forwarding off / on) with identical inputs.
// A directed table covers the named forwarding scenarios, hand sequences
// cover multi-cycle corners, and a random phase is compared each cycle
// against a pipeline-array reference model.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       st;
    logic [4:0] rd;
    logic       rw;
    logic [2:0] wb;
  } ins_t;

  typedef struct {
    ins_t id;
    logic br;
    logic iw;
    logic dw;
    logic chk_sel;
    int   e_rs1;
    int   e_rs2;
    int   e_dc;
    int   e_fz;
    int   e_st;
    int   e_fl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_is_store, id_regwrite;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_wb_sel;
  logic       br_taken, imem_wait, dmem_wait;

  logic [2:0] rs1_s [2];
  logic [2:0] rs2_s [2];
  logic       dc_s  [2];
  logic       fz_s  [2];
  logic       st_s  [2];
  logic       fl_s  [2];

  int n_checks = 0;
  int n_err    = 0;

  // model state: pipe[mode][0]=EX, [1]=MEM, [2]=WB; mode = MEM_RDATA_FWD
  ins_t pipe [2][3];
  // per producer regfilemux code, forwarded select when producer is in MEM; -1 = stall
  int   fwd_tab [2][5];

  ins_t nop, add5, add6_55, lui7, addi8_7, lw9, add10_9, jal1, add2_11;
  ins_t add0_34, add11_00, add3_12, sw_4_3, beq12, add12_11;
  vec_t tbl [28];

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_IDX_W(5), .MEM_RDATA_FWD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_store(id_is_store),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_wb_sel(id_wb_sel),
    .br_taken(br_taken), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .rs1mux_sel(rs1_s[0]), .rs2mux_sel(rs2_s[0]), .dcachemux_sel(dc_s[0]),
    .freeze(fz_s[0]), .stall_front(st_s[0]), .flush(fl_s[0]));

  hazard_forward_unit #(.REG_IDX_W(5), .MEM_RDATA_FWD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_store(id_is_store),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_wb_sel(id_wb_sel),
    .br_taken(br_taken), .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .rs1mux_sel(rs1_s[1]), .rs2mux_sel(rs2_s[1]), .dcachemux_sel(dc_s[1]),
    .freeze(fz_s[1]), .stall_front(st_s[1]), .flush(fl_s[1]));

  function automatic ins_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input logic st,
                              input int rd, input logic rw, input int wb);
    ins_t t;
    t.v = v; t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = u1; t.u2 = u2;
    t.st = st; t.rd = rd[4:0]; t.rw = rw; t.wb = wb[2:0];
    return t;
  endfunction

  function automatic vec_t mv(input ins_t id, input logic br, input logic iw, input logic dw,
                              input logic cs, input int e1, input int e2, input int dc,
                              input int fz, input int st, input int fl);
    vec_t r;
    r.id = id; r.br = br; r.iw = iw; r.dw = dw; r.chk_sel = cs;
    r.e_rs1 = e1; r.e_rs2 = e2; r.e_dc = dc; r.e_fz = fz; r.e_st = st; r.e_fl = fl;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input ins_t i, input logic br, input logic iw, input logic dw);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1;
    id_uses_rs2 = i.u2; id_is_store = i.st; id_rd = i.rd; id_regwrite = i.rw;
    id_wb_sel = i.wb; br_taken = br; imem_wait = iw; dmem_wait = dw;
  endtask

  function automatic bit writes(input ins_t p, input logic [4:0] r);
    return p.v && p.rw && (p.rd == r) && (r != 5'd0);
  endfunction

  // nearest older producer wins; MEM producer forwards per table, WB via regfile
  task automatic src_eval(input int m, input logic used, input logic [4:0] r,
                          output int sel, output bit haz);
    int code;
    sel = 0; haz = 1'b0; code = 0;
    if (pipe[m][0].v && used) begin
      for (int s = 1; s <= 2; s++) begin
        if (writes(pipe[m][s], r)) begin
          if (s == 1) code = (int'(pipe[m][1].wb) < 5) ? fwd_tab[m][pipe[m][1].wb] : -1;
          else        code = 3;
          break;
        end
      end
      if (code < 0) haz = 1'b1;
      else          sel = code;
    end
  endtask

  task automatic mdl_eval(input int m, output int s1, output int s2, output bit hz,
                          output bit dc, output bit fz, output bit st, output bit fl);
    bit h1, h2;
    src_eval(m, pipe[m][0].u1, pipe[m][0].rs1, s1, h1);
    src_eval(m, pipe[m][0].u2, pipe[m][0].rs2, s2, h2);
    hz = h1 | h2;
    fz = imem_wait | dmem_wait;
    st = hz && !fz;
    fl = br_taken && pipe[m][0].v && !hz && !fz;
    dc = pipe[m][1].v && pipe[m][1].st && writes(pipe[m][2], pipe[m][1].rs2);
  endtask

  task automatic model_check();
    int s1, s2;
    bit hz, dc, fz, st, fl;
    for (int m = 0; m < 2; m++) begin
      mdl_eval(m, s1, s2, hz, dc, fz, st, fl);
      if (!hz) begin
        chk($sformatf("mdl%0d.rs1", m), int'(rs1_s[m]), s1);
        chk($sformatf("mdl%0d.rs2", m), int'(rs2_s[m]), s2);
      end
      chk($sformatf("mdl%0d.dc", m), int'(dc_s[m]), int'(dc));
      chk($sformatf("mdl%0d.freeze", m), int'(fz_s[m]), int'(fz));
      chk($sformatf("mdl%0d.stall", m), int'(st_s[m]), int'(st));
      chk($sformatf("mdl%0d.flush", m), int'(fl_s[m]), int'(fl));
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < 3; s++)
        pipe[m][s] = '0;
  endtask

  task automatic model_step();
    int s1, s2;
    bit hz, dc, fz, st, fl;
    ins_t cur;
    cur = mk(id_valid, int'(id_rs1), int'(id_rs2), id_uses_rs1, id_uses_rs2,
             id_is_store, int'(id_rd), id_regwrite, int'(id_wb_sel));
    for (int m = 0; m < 2; m++) begin
      mdl_eval(m, s1, s2, hz, dc, fz, st, fl);
      if (!rst) begin
        for (int s = 0; s < 3; s++) pipe[m][s] = '0;
      end else if (!fz) begin
        pipe[m][2] = pipe[m][1];
        pipe[m][1] = hz ? ins_t'('0) : pipe[m][0];
        if (!hz) pipe[m][0] = fl ? ins_t'('0) : cur;
      end
    end
  endtask

  task automatic apply(input ins_t i, input logic br, input logic iw, input logic dw);
    @(negedge clk);
    drive(i, br, iw, dw);
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
  endtask

  task automatic chk_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s%0d.rs1", tag, m), int'(rs1_s[m]), 0);
      chk($sformatf("%s%0d.rs2", tag, m), int'(rs2_s[m]), 0);
      chk($sformatf("%s%0d.dc", tag, m), int'(dc_s[m]), 0);
      chk($sformatf("%s%0d.freeze", tag, m), int'(fz_s[m]), 0);
      chk($sformatf("%s%0d.stall", tag, m), int'(st_s[m]), 0);
      chk($sformatf("%s%0d.flush", tag, m), int'(fl_s[m]), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(nop, 1'b0, 1'b0, 1'b0);
    model_clear();
    @(negedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b1;
    adv();
  endtask

  initial begin
    fwd_tab[0] = '{1, 2, 5, -1, -1};
    fwd_tab[1] = '{1, 2, 5, 4, -1};

    //            v  rs1 rs2 u1 u2 st  rd rw wb
    nop      = mk(0, 0,  0,  0, 0, 0,  0, 0, 0);
    add5     = mk(1, 1,  2,  1, 1, 0,  5, 1, 0);
    add6_55  = mk(1, 5,  5,  1, 1, 0,  6, 1, 0);
    lui7     = mk(1, 0,  0,  0, 0, 0,  7, 1, 2);
    addi8_7  = mk(1, 7,  0,  1, 0, 0,  8, 1, 0);
    lw9      = mk(1, 1,  0,  1, 0, 0,  9, 1, 3);
    add10_9  = mk(1, 9,  0,  1, 1, 0, 10, 1, 0);
    jal1     = mk(1, 0,  0,  0, 0, 0,  1, 1, 4);
    add2_11  = mk(1, 1,  1,  1, 1, 0,  2, 1, 0);
    add0_34  = mk(1, 3,  4,  1, 1, 0,  0, 1, 0);
    add11_00 = mk(1, 0,  0,  1, 1, 0, 11, 1, 0);
    add3_12  = mk(1, 1,  2,  1, 1, 0,  3, 1, 0);
    sw_4_3   = mk(1, 4,  3,  1, 1, 1,  0, 0, 0);
    beq12    = mk(1, 1,  2,  1, 1, 0,  0, 0, 0);
    add12_11 = mk(1, 1,  1,  1, 1, 0, 12, 1, 0);

    // expectations for the mem_rdata-forwarding instance
    //            id        br iw dw cs rs1 rs2 dc fz st fl
    tbl[0]  = mv(add5,     0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mv(add6_55,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mv(nop,      0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    tbl[3]  = mv(lui7,     0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mv(nop,      0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mv(addi8_7,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mv(lui7,     0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    tbl[7]  = mv(addi8_7,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mv(lw9,      0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    tbl[9]  = mv(add10_9,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mv(nop,      0, 0, 1, 1, 4, 0, 0, 1, 0, 0);
    tbl[11] = mv(nop,      0, 0, 1, 1, 4, 0, 0, 1, 0, 0);
    tbl[12] = mv(nop,      0, 0, 1, 1, 4, 0, 0, 1, 0, 0);
    tbl[13] = mv(nop,      0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    tbl[14] = mv(jal1,     0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mv(add2_11,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = mv(nop,      0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[17] = mv(nop,      0, 0, 0, 1, 3, 3, 0, 0, 0, 0);
    tbl[18] = mv(add0_34,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[19] = mv(add11_00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[20] = mv(add3_12,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[21] = mv(sw_4_3,   0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[22] = mv(nop,      0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[23] = mv(nop,      0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[24] = mv(beq12,    0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[25] = mv(add12_11, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[26] = mv(nop,      1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[27] = mv(nop,      0, 1, 0, 1, 0, 0, 0, 1, 0, 0);

    do_reset();

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].id, tbl[i].br, tbl[i].iw, tbl[i].dw);
      if (tbl[i].chk_sel) begin
        chk($sformatf("tbl%0d.rs1", i), int'(rs1_s[1]), tbl[i].e_rs1);
        chk($sformatf("tbl%0d.rs2", i), int'(rs2_s[1]), tbl[i].e_rs2);
      end
      chk($sformatf("tbl%0d.dc", i), int'(dc_s[1]), tbl[i].e_dc);
      chk($sformatf("tbl%0d.freeze", i), int'(fz_s[1]), tbl[i].e_fz);
      chk($sformatf("tbl%0d.stall", i), int'(st_s[1]), tbl[i].e_st);
      chk($sformatf("tbl%0d.flush", i), int'(fl_s[1]), tbl[i].e_fl);
      adv();
    end

    // load-use without mem_rdata forwarding: exactly one stall, then regfile
    do_reset();
    apply(lw9, 0, 0, 0);     adv();
    apply(add10_9, 0, 0, 0); adv();
    apply(nop, 0, 0, 0);
    chk("lu0.stall", int'(st_s[0]), 1);
    chk("lu1.stall", int'(st_s[1]), 0);
    chk("lu1.rs1", int'(rs1_s[1]), 4);
    adv();
    apply(nop, 0, 0, 0);
    chk("lu0.stall_after", int'(st_s[0]), 0);
    chk("lu0.rs1_after", int'(rs1_s[0]), 3);
    adv();

    // reset asserted in the middle of a jal stall
    do_reset();
    apply(jal1, 0, 0, 0);    adv();
    apply(add2_11, 0, 0, 0); adv();
    apply(nop, 0, 0, 0);
    chk("ms0.stall", int'(st_s[0]), 1);
    chk("ms1.stall", int'(st_s[1]), 1);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    chk_zero("midrst");
    adv();
    apply(nop, 0, 0, 0);
    rst = 1'b1;
    adv();
    apply(add5, 0, 0, 0);    adv();
    apply(nop, 0, 0, 0);
    chk("postrst.rs1", int'(rs1_s[1]), 0);
    chk("postrst.stall", int'(st_s[1]), 0);
    adv();

    // random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      ins_t r;
      r.v   = ($urandom_range(0, 5) != 0);
      r.rs1 = 5'($urandom_range(0, 7));
      r.rs2 = 5'($urandom_range(0, 7));
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      r.st  = ($urandom_range(0, 4) == 0);
      r.rd  = 5'($urandom_range(0, 7));
      r.rw  = ($urandom_range(0, 3) != 0);
      r.wb  = 3'($urandom_range(0, 4));
      apply(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 11) == 0));
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
